mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter memory_bits, default 5, address width shared with the cache.
REQ-002 Parameter index, default 3, cache index width; tag is memory_bits-index bits.
REQ-003 Parameter miss_cycles, default 4, main-memory penalty in cycles, legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  processor request valid; sampled only while cpu_ready=1.
REQ-007 cpu_we  input  1  1=store, 0=load; qualified by cpu_req.
REQ-008 cpu_addr  input  memory_bits  request address.
REQ-009 cpu_wdata  input  32  store data.
REQ-010 cpu_ready  output  1  controller idle and accepting a request.
REQ-011 cpu_done  output  1  one-cycle completion pulse.
REQ-012 cpu_rdata  output  32  load result, valid when cpu_done=1, held until next completion.
REQ-013 cpu_hit  output  1  lookup outcome of completing access, valid with cpu_done.
REQ-014 cache_addr  output  memory_bits  drives cache fulladdress.
REQ-015 cache_wdata  output  32  drives cache write_data.
REQ-016 cache_read  output  1  drives cache read_signal.
REQ-017 cache_write  output  1  drives cache write_signal.
REQ-018 cache_rdata  input  32  cache read_data.
REQ-019 cache_match  input  1  cache match.
REQ-020 hit_count  output  16  count of load hits.
REQ-021 miss_count  output  16  count of load misses.

Function
REQ-022 FSM states IDLE, LOOKUP, MISS_WAIT, RESP; cpu_ready=1 only in IDLE.
REQ-023 IDLE with cpu_req=1 at edge N: latch cpu_addr/cpu_wdata/cpu_we, enter LOOKUP for cycle N+1.
REQ-024 LOOKUP: cache_addr/cache_wdata = latched values; cache_read=~we, cache_write=we, each for exactly this cycle; cache_match sampled at end of cycle.
REQ-025 Load hit: capture cache_rdata into cpu_rdata, cpu_hit=1, enter RESP (done in cycle N+2); hit_count increments.
REQ-026 Load miss: cpu_hit=0, miss_count increments, enter MISS_WAIT, timer loaded miss_cycles-1.
REQ-027 Store (hit or miss): write-through; cpu_hit=cache_match, enter MISS_WAIT, timer loaded miss_cycles-1; counters unchanged.
REQ-028 MISS_WAIT: timer decrements each cycle; cache_addr held; on timer=0 cycle, loads reassert cache_read and capture cache_rdata into cpu_rdata; then enter RESP; miss/store done in cycle N+2+miss_cycles.
REQ-029 RESP: cpu_done=1 for one cycle, return to IDLE; cpu_ready=0 during RESP (no back-to-back acceptance).
REQ-030 cpu_req outside IDLE is ignored; no queueing.
REQ-031 cache_read and cache_write never both 1; both 0 in IDLE and RESP.
REQ-032 hit_count/miss_count saturate at 16'hFFFF.
REQ-033 miss_cycles=1: MISS_WAIT lasts exactly one cycle.

Reset
REQ-034 reset=1 at any edge: state IDLE, cpu_ready=1 next cycle, cpu_done=0, cpu_hit=0, cpu_rdata=0, cache_* outputs 0, timer 0, both counters 0.
REQ-035 Reset mid-access abandons the access; no cpu_done is produced for it.

Structure
REQ-036 Shared package cache_pkg holds memory_bits/index defaults, miss_cycles default, state encoding (2 bits: IDLE=0, LOOKUP=1, MISS_WAIT=2, RESP=3).
REQ-037 One sub-module miss_timer: 4-bit loadable down-counter with zero flag, clk/reset ports as above.

Verification
REQ-038 After reset, preload addr 5'h03 data 32'hA5A5_0001 via store; load 5'h03 with cache_match=1 -> cpu_done at N+2, cpu_rdata=32'hA5A5_0001, cpu_hit=1, hit_count=1.
REQ-039 Load 5'h1B with cache_match=0 -> cache_read high in LOOKUP and last MISS_WAIT cycle, cpu_done at N+6, cpu_hit=0, miss_count=1.
REQ-040 Store 5'h0A, 32'hDEAD_BEEF -> cache_write high one cycle only, cache_wdata=32'hDEAD_BEEF, cpu_done at N+6, counters unchanged.
REQ-041 Hold cpu_req=1 continuously with 3 loads -> each accepted only in IDLE, completions spaced by RESP/IDLE, never two cpu_done in consecutive cycles.
REQ-042 Assert reset during MISS_WAIT -> next cycle state IDLE, cpu_ready=1, no cpu_done, counters 0.
REQ-043 Force hit_count to 16'hFFFF then load hit -> hit_count stays 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-controller definitions: address geometry defaults, miss penalty, FSM encoding.
package cache_pkg;

  localparam int MEMORY_BITS_DEF = 5;
  localparam int INDEX_DEF       = 3;
  localparam int MISS_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_MISS_WAIT = 2'd2,
    S_RESP      = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/miss_timer.sv
// Loadable 4-bit down-counter with zero flag; counts main-memory penalty cycles.
module miss_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU-to-cache access controller: load hit done 2 cycles after accept,
// miss/store done 2+miss_cycles after; accepts only when idle, extra requests are dropped.
module mem_access_ctrl
  import cache_pkg::*;
#(
  parameter int memory_bits = MEMORY_BITS_DEF,
  parameter int index       = INDEX_DEF,
  parameter int miss_cycles = MISS_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [memory_bits-1:0] cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_hit,
  output logic [memory_bits-1:0] cache_addr,
  output logic [31:0]            cache_wdata,
  output logic                   cache_read,
  output logic                   cache_write,
  input  logic [31:0]            cache_rdata,
  input  logic                   cache_match,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  state_e                 state_q, state_d;
  logic [memory_bits-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   hit_q, hit_d;
  logic [15:0]            hit_cnt_q, hit_cnt_d;
  logic [15:0]            miss_cnt_q, miss_cnt_d;

  logic tmr_load, tmr_dec, tmr_zero;

  miss_timer u_miss_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (4'(miss_cycles - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    cache_read  = 1'b0;
    cache_write = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // tag field above the index field forms the cache's full address
        cache_addr  = {addr_q[memory_bits-1:index], addr_q[index-1:0]};
        cache_wdata = wdata_q;
        cache_read  = ~we_q;
        cache_write = we_q;
        if (!we_q && cache_match) begin
          rdata_d   = cache_rdata;
          hit_d     = 1'b1;
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = S_RESP;
        end else begin
          hit_d    = we_q & cache_match;
          tmr_load = 1'b1;
          state_d  = S_MISS_WAIT;
          if (!we_q) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end
      end
      S_MISS_WAIT: begin
        cache_addr  = {addr_q[memory_bits-1:index], addr_q[index-1:0]};
        cache_wdata = wdata_q;
        if (tmr_zero) begin
          // loads re-read once the line has been filled from main memory
          cache_read = ~we_q;
          if (!we_q) begin
            rdata_d = cache_rdata;
          end
          state_d = S_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cpu_ready  = (state_q == S_IDLE);
  assign cpu_done   = (state_q == S_RESP);
  assign cpu_rdata  = rdata_q;
  assign cpu_hit    = hit_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus random bench for mem_access_ctrl; the bench plays the cache and keeps a transaction-level model.
module tb_mem_access_ctrl;

  localparam int MB = 5;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [MB-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_ready, cpu_done, cpu_hit;
  logic [31:0]   cpu_rdata;
  logic [MB-1:0] cache_addr;
  logic [31:0]   cache_wdata, cache_rdata;
  logic          cache_read, cache_write, cache_match;
  logic [15:0]   hit_count, miss_count;

  mem_access_ctrl #(.memory_bits(MB), .index(3), .miss_cycles(MC)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_rdata(cache_rdata), .cache_match(cache_match),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // cache/backing store emulation
  logic [31:0] mem [32];
  assign cache_rdata = mem[cache_addr];
  always @(posedge clk) if (cache_write) mem[cache_addr] = cache_wdata;

  // transaction-level model
  logic [31:0] exp_mem [32];
  int          exp_hits, exp_misses;
  logic [31:0] exp_rdata;
  logic        exp_hit;

  int total = 0;
  int passed = 0;

  // protocol monitor
  int  err_both = 0, err_idle = 0, err_dbl = 0;
  bit  prev_done = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (cache_read && cache_write) err_both++;
      if ((cpu_ready || cpu_done) && (cache_read || cache_write)) err_idle++;
      if (cpu_done && prev_done) err_dbl++;
      prev_done = cpu_done;
    end else begin
      prev_done = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // one access from an idle cycle; returns at the negedge of the following idle cycle
  task automatic access(input bit we, input logic [4:0] a, input logic [31:0] wd,
                        input bit m, input string tag);
    int lat = 0, nrd = 0, nwr = 0, rd_last = 0, exp_lat;
    bit done = 0, addr_ok = 1, wd_ok = 1;
    check({tag, "_ready"}, cpu_ready, 1);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cache_match = m;
    @(posedge clk);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      cpu_req = 0;
      if (cache_read) begin
        nrd++; rd_last = c;
        if (cache_addr !== a) addr_ok = 0;
      end
      if (cache_write) begin
        nwr++;
        if (cache_addr !== a || cache_wdata !== wd) wd_ok = 0;
      end
      if (cpu_done) begin done = 1; lat = c; end
    end
    exp_lat = (!we && m) ? 2 : 2 + MC;
    exp_hit = m;
    if (we) exp_mem[a] = wd;
    else begin
      exp_rdata = exp_mem[a];
      if (m) exp_hits = sat16(exp_hits);
      else   exp_misses = sat16(exp_misses);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rdata"}, cpu_rdata, exp_rdata);
    check({tag, "_hit"}, cpu_hit, exp_hit);
    check({tag, "_hit_count"}, hit_count, exp_hits);
    check({tag, "_miss_count"}, miss_count, exp_misses);
    check({tag, "_n_read"}, nrd, we ? 0 : (m ? 1 : 2));
    check({tag, "_last_read_cycle"}, rd_last, we ? 0 : (m ? 1 : 1 + MC));
    check({tag, "_n_write"}, nwr, we ? 1 : 0);
    check({tag, "_addr_ok"}, addr_ok, 1);
    check({tag, "_wdata_ok"}, wd_ok, 1);
    @(negedge clk);
  endtask

  initial begin
    int ndone, first_done, last_done, gap_bad, late_done;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cache_match = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      exp_mem[i] = mem[i];
    end
    exp_hits = 0; exp_misses = 0; exp_rdata = '0; exp_hit = 0;

    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cpu_ready, 1);
    check("rst_done", cpu_done, 0);
    check("rst_hit", cpu_hit, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_cache_rw", {cache_read, cache_write}, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_cache_wdata", cache_wdata, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    reset = 0;
    @(negedge clk);

    access(1, 5'h03, 32'hA5A5_0001, 0, "preload_store");
    access(0, 5'h03, 32'h0, 1, "load_hit");
    check("load_hit_value", cpu_rdata, 32'hA5A5_0001);
    access(0, 5'h1B, 32'h0, 0, "load_miss");
    access(1, 5'h0A, 32'hDEAD_BEEF, 1, "store");

    for (int i = 0; i < 24; i++)
      access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));

    // request held high across three back-to-back load hits
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h0A; cache_match = 1;
    ndone = 0; first_done = 0; last_done = 0; gap_bad = 0;
    @(posedge clk);
    for (int c = 1; c <= 60 && ndone < 3; c++) begin
      @(negedge clk);
      if (cpu_done) begin
        if (ndone == 0) first_done = c;
        else if (c - last_done != 3) gap_bad++;
        last_done = c;
        ndone++;
        if (ndone == 3) cpu_req = 0;
      end
    end
    repeat (3) exp_hits = sat16(exp_hits);
    exp_rdata = exp_mem[5'h0A];
    check("held_req_ndone", ndone, 3);
    check("held_req_first", first_done, 2);
    check("held_req_spacing", gap_bad, 0);
    check("held_req_hit_count", hit_count, exp_hits);
    check("held_req_rdata", cpu_rdata, exp_rdata);
    @(negedge clk);

    // reset in the middle of a miss
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h1B; cache_match = 0;
    @(posedge clk);
    @(negedge clk); cpu_req = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrst_ready", cpu_ready, 1);
    check("midrst_done", cpu_done, 0);
    check("midrst_hit_count", hit_count, 0);
    check("midrst_miss_count", miss_count, 0);
    check("midrst_rdata", cpu_rdata, 0);
    check("midrst_cache_read", cache_read, 0);
    reset = 0;
    exp_hits = 0; exp_misses = 0; exp_rdata = '0; exp_hit = 0;
    late_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_done) late_done++;
    end
    check("midrst_no_done", late_done, 0);

    // saturation of the hit counter
    force dut.hit_cnt_q = 16'hFFFF;
    #1;
    release dut.hit_cnt_q;
    exp_hits = 65535;
    check("sat_preset", hit_count, 16'hFFFF);
    access(0, 5'h03, 32'h0, 1, "sat_hit");

    check("mon_read_and_write", err_both, 0);
    check("mon_rw_outside_access", err_idle, 0);
    check("mon_consecutive_done", err_dbl, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
